// File: rtl/quire_dot_product_sequencer_if.sv
// Host-facing stream bundle for the quire dot-product sequencer.
// The host drives operand pairs and outReady; the sequencer returns rounded results.
interface quire_dot_product_sequencer_if #(
   parameter int WIDTH      = 8,
   parameter int COUNT_BITS = 16
);
   logic                  inValid;
   logic                  inReady;
   logic [WIDTH-1:0]      inA;
   logic [WIDTH-1:0]      inB;
   logic                  inLast;
   logic                  outValid;
   logic                  outReady;
   logic [WIDTH-1:0]      outData;
   logic [COUNT_BITS-1:0] outCount;
   logic                  busy;

   modport slave (
      input  inValid, inA, inB, inLast, outReady,
      output inReady, outValid, outData, outCount, busy
   );

   modport master (
      output inValid, inA, inB, inLast, outReady,
      input  inReady, outValid, outData, outCount, busy
   );
endinterface

// File: rtl/quire_dot_product_sequencer.sv
// Streaming posit dot product: exact products summed in a Kulisch quire,
// one RNE rounding to a posit when the last term has been accumulated.
module quire_dot_product_sequencer #(
   parameter int WIDTH      = 8,
   parameter int ES         = 1,
   parameter int OVERFLOW   = 0,
   parameter int COUNT_BITS = 16
) (
   input logic                          clock,
   input logic                          resetn,
   quire_dot_product_sequencer_if.slave io_bus
);
   localparam int MAXSCALE     = (WIDTH - 2) * (1 << ES);
   localparam int FB           = WIDTH - 3 - ES;
   localparam int MW           = FB + 1;
   localparam int ACC_FRAC     = 2 * MAXSCALE;
   localparam int ACC_NON_FRAC = 2 * MAXSCALE + 2 + OVERFLOW;
   localparam int QW           = ACC_NON_FRAC + ACC_FRAC;
   localparam int AW           = 4 * MAXSCALE + 2;
   localparam int XW           = AW + 2 * FB;
   localparam int SW           = ((AW > QW) ? AW : QW) + 2;
   localparam int SCW          = $clog2(2 * MAXSCALE + 1) + 2;
   localparam int BW           = QW + ES + 2;

   typedef struct packed {
      logic           nar;
      logic           zero;
      logic           sign;
      logic [SCW-1:0] scale;
      logic [MW-1:0]  mant;
   } dec_t;

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH, S_CONVERT, S_OUTPUT} state_t;

   function automatic dec_t decode(input logic [WIDTH-1:0] pz);
      dec_t             d;
      logic [WIDTH-1:0] mag;
      logic [WIDTH-2:0] r, rest;
      logic             r0, run;
      int               m, k, e;
      d      = '0;
      d.nar  = (pz == {1'b1, {(WIDTH-1){1'b0}}});
      d.zero = (pz == '0);
      d.sign = pz[WIDTH-1];
      mag    = d.sign ? -pz : pz;
      r      = (WIDTH-1)'(mag);
      r0     = r[WIDTH-2];
      m      = 0;
      run    = 1'b1;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (run && (r[i] == r0)) m++;
         else run = 1'b0;
      end
      k       = r0 ? m - 1 : -m;
      rest    = r << (m + 1);
      e       = int'(rest >> (WIDTH - 1 - ES));
      d.scale = SCW'(k * (1 << ES) + e);
      d.mant  = {1'b1, FB'(rest >> 2)};
      return d;
   endfunction

   // The bit string {regime, exponent, fraction} is built with a one-bit regime and
   // then arithmetically shifted so the regime run fills in from the top bit.
   function automatic logic [WIDTH-1:0] to_posit(input logic [QW-1:0] q, input logic inf);
      logic [QW-1:0]    mag, frac;
      logic [BW-1:0]    base, sh_v;
      logic [WIDTH-2:0] body;
      logic [WIDTH-1:0] res;
      logic             sgn, r0, g, st;
      int               p, sc, k, e;
      sgn = q[QW-1];
      mag = sgn ? -q : q;
      p   = 0;
      for (int i = 0; i < QW; i++) if (mag[i]) p = i;
      sc   = p - ACC_FRAC;
      k    = sc >>> ES;
      e    = sc - k * (1 << ES);
      r0   = (k >= 0);
      frac = mag << (QW - p);
      base = (BW'({r0, ~r0}) << (ES + QW)) | (BW'(e) << QW) | BW'(frac);
      sh_v = BW'($signed(base) >>> (r0 ? k : -k - 1));
      body = sh_v[BW-1 -: WIDTH-1];
      g    = sh_v[BW-WIDTH];
      st   = |sh_v[BW-WIDTH-1:0];
      // Posits never round to zero or NaR: clamp to minpos/maxpos.
      if (sc > MAXSCALE) body = '1;
      else if (sc < -MAXSCALE) body = (WIDTH-1)'(1);
      else if (g && (st || body[0]) && !(&body)) body = body + (WIDTH-1)'(1);
      res = {1'b0, body};
      if (sgn) res = -res;
      if (inf) res = {1'b1, {(WIDTH-1){1'b0}}};
      else if (q == '0) res = '0;
      return res;
   endfunction

   state_t                r_state;
   logic                  r_in_ready, r_out_valid, r_busy;
   logic [WIDTH-1:0]      r_out_data;
   logic [COUNT_BITS-1:0] r_out_count, r_cnt;
   logic                  r_p_vld, r_p_nar, r_p_zero, r_p_sign;
   logic [SCW-1:0]        r_p_scale;
   logic [2*MW-1:0]       r_p_mant;
   logic [QW-1:0]         r_quire;
   logic                  r_inf;

   dec_t                  w_da, w_db;
   logic                  w_in_hs, w_out_hs, w_fits;
   int                    w_shamt;
   logic [SW-1:0]         w_pmag, w_padd, w_qext, w_sum;
   logic [QW-1:0]         w_q_next;

   assign w_da     = decode(io_bus.inA);
   assign w_db     = decode(io_bus.inB);
   assign w_in_hs  = io_bus.inValid && r_in_ready;
   assign w_out_hs = r_out_valid && io_bus.outReady;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_p_vld   <= 1'b0;
         r_p_nar   <= 1'b0;
         r_p_zero  <= 1'b0;
         r_p_sign  <= 1'b0;
         r_p_scale <= '0;
         r_p_mant  <= '0;
      end else begin
         r_p_vld <= w_in_hs;
         if (w_in_hs) begin
            r_p_nar   <= w_da.nar | w_db.nar;
            r_p_zero  <= w_da.zero | w_db.zero;
            r_p_sign  <= w_da.sign ^ w_db.sign;
            r_p_scale <= w_da.scale + w_db.scale;
            r_p_mant  <= (2*MW)'(w_da.mant) * (2*MW)'(w_db.mant);
         end
      end
   end

   // Product LSB weighs 2^(scale-2*FB); scale >= -ACC_FRAC keeps the shift non-negative.
   always_comb begin
      w_shamt  = int'($signed(r_p_scale)) + ACC_FRAC;
      w_pmag   = SW'(AW'((XW'(r_p_mant) << w_shamt) >> (2 * FB)));
      w_padd   = (r_p_vld && !r_p_zero && !r_p_nar) ? (r_p_sign ? -w_pmag : w_pmag) : '0;
      w_qext   = {{(SW-QW){r_quire[QW-1]}}, r_quire};
      w_sum    = w_qext + w_padd;
      w_fits   = (&w_sum[SW-1:QW-1]) || !(|w_sum[SW-1:QW-1]);
      w_q_next = w_fits ? w_sum[QW-1:0]
                        : (w_sum[SW-1] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}});
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_quire <= '0;
         r_inf   <= 1'b0;
      end else if (w_out_hs) begin
         r_quire <= '0;
         r_inf   <= 1'b0;
      end else if (r_p_vld) begin
         r_quire <= w_q_next;
         r_inf   <= r_inf | r_p_nar;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_cnt <= '0;
      else if (w_out_hs) r_cnt <= '0;
      else if (w_in_hs && !(&r_cnt)) r_cnt <= r_cnt + COUNT_BITS'(1);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_ACCUM: begin
               if (w_in_hs) begin
                  r_busy <= 1'b1;
                  if (io_bus.inLast) begin
                     r_state    <= S_FLUSH;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_state <= S_ACCUM;
                  end
               end
            end
            S_FLUSH: r_state <= S_CONVERT;
            S_CONVERT: begin
               r_out_data  <= to_posit(r_quire, r_inf);
               r_out_count <= r_cnt;
               r_out_valid <= 1'b1;
               r_state     <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (io_bus.outReady) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.inReady  = r_in_ready;
   assign io_bus.outValid = r_out_valid;
   assign io_bus.outData  = r_out_data;
   assign io_bus.outCount = r_out_count;
   assign io_bus.busy     = r_busy;
endmodule

// File: tb/tb_quire_dot_product_sequencer.sv
// Directed bench: table of hand-computed dot products plus backpressure and mid-run reset.
module tb_quire_dot_product_sequencer;
   localparam int W  = 8;
   localparam int CB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   quire_dot_product_sequencer_if #(.WIDTH(W), .COUNT_BITS(CB)) bus ();

   quire_dot_product_sequencer #(.WIDTH(W), .ES(1), .OVERFLOW(0), .COUNT_BITS(CB)) dut (
      .clock (clk),
      .resetn(rst_n),
      .io_bus(bus)
   );

   // Term j of a vector lives in bits [8j +: 8] of a and b.
   typedef struct {
      int          n;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  d;
      int          cnt;
   } vec_t;

   vec_t tv[15];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                               input logic [7:0] d, input int cnt);
      vec_t v;
      v.n = n; v.a = a; v.b = b; v.d = d; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Streams the terms back to back, then checks the exact 3-edge latency and result.
   task automatic run_vec(input vec_t v, input int id);
      for (int j = 0; j < v.n; j++) begin
         @(negedge clk);
         chk($sformatf("v%0d inReady beat%0d", id, j), 32'(bus.inReady), 32'd1);
         bus.inValid = 1'b1;
         bus.inA     = v.a[8*j +: 8];
         bus.inB     = v.b[8*j +: 8];
         bus.inLast  = (j == v.n - 1);
      end
      @(negedge clk);
      bus.inValid = 1'b0;
      bus.inLast  = 1'b0;
      chk($sformatf("v%0d outValid edge1", id), 32'(bus.outValid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d outValid edge2", id), 32'(bus.outValid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d outValid edge3", id), 32'(bus.outValid), 32'd1);
      chk($sformatf("v%0d outData", id), 32'(bus.outData), 32'(v.d));
      chk($sformatf("v%0d outCount", id), 32'(bus.outCount), 32'(v.cnt));
      chk($sformatf("v%0d inReady out", id), 32'(bus.inReady), 32'd0);
      chk($sformatf("v%0d busy out", id), 32'(bus.busy), 32'd1);
   endtask

   task automatic take_out(input int id);
      bus.outReady = 1'b1;
      @(negedge clk);
      bus.outReady = 1'b0;
      chk($sformatf("v%0d outValid after hs", id), 32'(bus.outValid), 32'd0);
      chk($sformatf("v%0d inReady after hs", id), 32'(bus.inReady), 32'd1);
      chk($sformatf("v%0d busy after hs", id), 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " outValid"}, 32'(bus.outValid), 32'd0);
      chk({tag, " outData"}, 32'(bus.outData), 32'd0);
      chk({tag, " outCount"}, 32'(bus.outCount), 32'd0);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " inReady"}, 32'(bus.inReady), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.inValid  = 1'b0;
      bus.inA      = '0;
      bus.inB      = '0;
      bus.inLast   = 1'b0;
      bus.outReady = 1'b0;

      tv[0]  = mk(1, 32'h00000040, 32'h00000050, 8'h50, 1);  // 1*2
      tv[1]  = mk(4, 32'h30404040, 32'h40C04040, 8'h48, 4);  // 1+1-1+0.5
      tv[2]  = mk(3, 32'h00017F7F, 32'h0040817F, 8'h01, 3);  // exact cancellation
      tv[3]  = mk(3, 32'h00408040, 32'h00404040, 8'h80, 3);  // NaR in the middle
      tv[4]  = mk(1, 32'h00000040, 32'h00000040, 8'h40, 1);  // NaR flag cleared
      tv[5]  = mk(1, 32'h0000007F, 32'h0000007F, 8'h7F, 1);  // 2^24 clamps to maxpos
      tv[6]  = mk(1, 32'h00000001, 32'h00000001, 8'h01, 1);  // 2^-24 clamps to minpos
      tv[7]  = mk(1, 32'h00000000, 32'h00000040, 8'h00, 1);  // zero term
      tv[8]  = mk(2, 32'h00004040, 32'h00000C40, 8'h40, 2);  // 1+1/32 tie to even (down)
      tv[9]  = mk(2, 32'h00004040, 32'h00001440, 8'h42, 2);  // 1+3/32 tie to even (up)
      tv[10] = mk(1, 32'h000000C0, 32'h00000050, 8'hB0, 1);  // -2
      tv[11] = mk(1, 32'h00000048, 32'h00000048, 8'h52, 1);  // 2.25
      tv[12] = mk(1, 32'h00000041, 32'h00000041, 8'h42, 1);  // 1.1289 rounds down
      tv[13] = mk(2, 32'h00000000, 32'h00007F00, 8'h00, 2);  // two zero terms
      tv[14] = mk(1, 32'h00000000, 32'h00000080, 8'h80, 1);  // 0 * NaR

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset inReady", 32'(bus.inReady), 32'd1);
      chk("post-reset busy", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 15; i++) begin
         run_vec(tv[i], i);
         take_out(i);
      end

      // Backpressure: result holds while the consumer stalls.
      run_vec(tv[0], 100);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp outValid", 32'(bus.outValid), 32'd1);
         chk("bp outData", 32'(bus.outData), 32'h50);
         chk("bp outCount", 32'(bus.outCount), 32'd1);
         chk("bp inReady", 32'(bus.inReady), 32'd0);
         chk("bp busy", 32'(bus.busy), 32'd1);
      end
      take_out(100);

      // Reset with a partial sum in the quire and a product still in flight.
      @(negedge clk);
      bus.inValid = 1'b1;
      bus.inA     = 8'h50;
      bus.inB     = 8'h50;
      bus.inLast  = 1'b0;
      @(negedge clk);
      chk("mid inReady beat2", 32'(bus.inReady), 32'd1);
      @(negedge clk);
      bus.inValid = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk_reset_outputs("mid-reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk(1, 32'h00000040, 32'h00000040, 8'h40, 1), 200);
      take_out(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
